// File: rtl/pwm_cfg_pkg.sv
// pwm_cfg_pkg: shared FSM state type and frame layout constants for the PWM config loader
package pwm_cfg_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, COMMIT} state_t;
  localparam int FRAME_BITS = 16;
  localparam int SEL_BIT = 15;
  localparam int RSVD_MSB = 14;
  localparam int RSVD_LSB = 12;
  localparam int DUTY_MAX_DEFAULT = 100;
endpackage

// File: rtl/pwm_cfg_sync.sv
// pwm_cfg_sync: STAGES-deep single-bit synchroniser with selectable reset level
// ports: clk, rst (async, active high), i_d async input, o_q synchronised output
module pwm_cfg_sync #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_ff;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ff <= {STAGES{RST_VAL}};
    else r_ff <= {r_ff[STAGES-2:0], i_d};
  assign o_q = r_ff[STAGES-1];
endmodule

// File: rtl/pwm_cfg_spi_loader.sv
// pwm_cfg_spi_loader: SPI mode-0 slave that validates 16-bit frames and issues single-cycle PWM config writes
// ports: clk, rst (async, active high); spi_sclk/spi_mosi/spi_cs_n async serial pins;
//        cfg_data/cfg_sel/cfg_wr_en registered PWM write; frame_err reject pulse; busy while shifting
module pwm_cfg_spi_loader import pwm_cfg_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W = 12,
  parameter int DUTY_MAX = DUTY_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic [DATA_W-1:0] cfg_data,
  output logic              cfg_sel,
  output logic              cfg_wr_en,
  output logic              frame_err,
  output logic              busy
);
  logic w_sclk, w_mosi, w_cs;
  pwm_cfg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (.clk(clk), .rst(rst), .i_d(spi_sclk), .o_q(w_sclk));
  pwm_cfg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (.clk(clk), .rst(rst), .i_d(spi_mosi), .o_q(w_mosi));
  pwm_cfg_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (.clk(clk), .rst(rst), .i_d(spi_cs_n), .o_q(w_cs));
  logic r_sclk_d, r_cs_d, r_armed;
  logic [SYNC_STAGES-1:0] r_flush;
  state_t r_state, w_next;
  logic [FRAME_BITS-1:0] r_sr;
  logic [4:0] r_cnt;
  logic [DATA_W-1:0] r_data;
  logic r_sel, r_wr_en;
  logic w_sclk_rise, w_cs_fall, w_cs_rise, w_accept, w_load, w_err, w_busy;
  logic [DATA_W-1:0] w_data, w_clamp;
  // r_flush marks when the synchroniser holds real pin samples; a frame start is only
  // trusted once cs_n has been seen high after that, so cs_n held low through reset never opens a frame
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_cs_fall = r_armed & r_cs_d & ~w_cs;
  assign w_cs_rise = w_cs & ~r_cs_d;
  assign w_accept = r_cnt == 5'(FRAME_BITS) && r_sr[RSVD_MSB:RSVD_LSB] == '0;
  assign w_data = DATA_W'(r_sr[11:0]);
  assign w_clamp = w_data > DATA_W'(DUTY_MAX) ? DATA_W'(DUTY_MAX) : w_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state == IDLE  ? (w_cs_fall ? SHIFT : IDLE) :
             r_state == SHIFT ? (w_cs_rise ? CHECK : SHIFT) :
             r_state == CHECK ? (w_accept ? COMMIT : IDLE) : IDLE;
  end
  always_comb begin
    w_busy = r_state == SHIFT;
    w_err = r_state == CHECK && !w_accept;
    w_load = r_state == CHECK && w_accept;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sclk_d <= 1'b0;
      r_cs_d <= 1'b1;
      r_flush <= '0;
      r_armed <= 1'b0;
      r_sr <= '0;
      r_cnt <= '0;
      r_data <= '0;
      r_sel <= 1'b0;
      r_wr_en <= 1'b0;
    end else begin
      r_sclk_d <= w_sclk;
      r_cs_d <= w_cs;
      r_flush <= {r_flush[SYNC_STAGES-2:0], 1'b1};
      r_armed <= r_armed | (r_flush[SYNC_STAGES-1] & w_cs);
      if (r_state == IDLE && w_cs_fall) begin
        r_sr <= '0;
        r_cnt <= '0;
      end else if (r_state == SHIFT && w_sclk_rise) begin
        r_sr <= {r_sr[FRAME_BITS-2:0], w_mosi};
        r_cnt <= r_cnt == 5'(FRAME_BITS + 1) ? r_cnt : r_cnt + 5'd1;
      end
      // loading at the end of CHECK makes the strobe and payload registered during COMMIT
      r_wr_en <= w_load;
      if (w_load) begin
        r_sel <= r_sr[SEL_BIT];
        r_data <= r_sr[SEL_BIT] ? w_data : w_clamp;
      end
    end
  assign cfg_data = r_data;
  assign cfg_sel = r_sel;
  assign cfg_wr_en = r_wr_en;
  assign frame_err = w_err;
  assign busy = w_busy;
endmodule
